// File: rtl/ntt_scheduler.sv
// Round-robin owner selection and per-polynomial sequencing for the shared NTT engine.
// Only control flows through here; the polynomial muxes follow grant/poly_idx.
module ntt_scheduler #(
  parameter int NUM_REQ = 3,
  parameter int LEN_W   = 2,
  parameter int TIMEOUT = 4096,
  parameter int WD_W    = 13
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*LEN_W-1:0] req_len,
  output logic [NUM_REQ-1:0]       grant,
  output logic [LEN_W-1:0]         poly_idx,
  output logic                     ntt_rst,
  output logic                     ntt_en,
  input  logic                     ntt_valid,
  output logic                     poly_done,
  output logic [NUM_REQ-1:0]       req_done,
  output logic                     err,
  output logic                     busy,
  output logic [2:0]               dbg_state
);

  // Handshake: req is a level held by the requester; it is sampled only in IDLE,
  // grant is one-hot for the whole burst, and req_done/err pulse once to close it.

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CLR  = 3'd1,
    S_RUN  = 3'd2,
    S_CAPT = 3'd3,
    S_FIN  = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [LEN_W-1:0]   idx_q, idx_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic [WD_W-1:0]    wd_q, wd_d;

  logic               found_hi, found_lo;
  logic [IDX_W-1:0]   sel_hi, sel_lo, sel_idx;
  logic [LEN_W-1:0]   sel_len;

  // Rotating priority: first request at or above the pointer, else the lowest one.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    sel_hi   = '0;
    sel_lo   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req[i] && !found_lo) begin
        found_lo = 1'b1;
        sel_lo   = IDX_W'(i);
      end
      if (req[i] && !found_hi && (IDX_W'(i) >= rr_q)) begin
        found_hi = 1'b1;
        sel_hi   = IDX_W'(i);
      end
    end
    sel_idx = found_hi ? sel_hi : sel_lo;
    sel_len = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel_idx == IDX_W'(i)) sel_len = req_len[i*LEN_W +: LEN_W];
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    len_d   = len_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    wd_d    = wd_q;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          grant_d = NUM_REQ'(1) << sel_idx;
          owner_d = sel_idx;
          len_d   = sel_len;
          idx_d   = '0;
          state_d = S_CLR;
        end
      end
      S_CLR: begin
        wd_d    = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        wd_d = wd_q + 1'b1;
        // wd_q is zero only in the first RUN cycle, where a stale valid is ignored.
        if ((wd_q != '0) && ntt_valid) begin
          state_d = S_CAPT;
        end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
          state_d = S_ERR;
        end
      end
      S_CAPT: begin
        if (idx_q == len_q) begin
          state_d = S_FIN;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_CLR;
        end
      end
      S_FIN, S_ERR: begin
        grant_d = '0;
        idx_d   = '0;
        rr_d    = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        grant_d = '0;
        idx_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they appear registered and Moore on state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      idx_q     <= '0;
      len_q     <= '0;
      owner_q   <= '0;
      rr_q      <= '0;
      wd_q      <= '0;
      ntt_rst   <= 1'b1;
      ntt_en    <= 1'b0;
      poly_done <= 1'b0;
      req_done  <= '0;
      err       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      owner_q   <= owner_d;
      rr_q      <= rr_d;
      wd_q      <= wd_d;
      ntt_rst   <= (state_d == S_IDLE) || (state_d == S_CLR);
      ntt_en    <= (state_d == S_RUN);
      poly_done <= (state_d == S_CAPT);
      req_done  <= (state_d == S_FIN) ? grant_d : '0;
      err       <= (state_d == S_ERR);
      busy      <= (state_d != S_IDLE);
    end
  end

  assign grant     = grant_q;
  assign poly_idx  = idx_q;
  assign dbg_state = state_q;

endmodule

// File: doc/ntt_scheduler.md
Name: ntt_scheduler

Overview:
- Round-robin arbiter and sequencer that shares the single 256-point NTT engine among NUM_REQ requesters (keygen, encrypt, decrypt polyvec paths).
- Each grant runs a burst of 1..2^LEN_W polynomials back-to-back.
- Drives the engine's reset/enable pins, watches its valid flag and steers the external polynomial muxes via grant/poly_idx.
- No polynomial data passes through this block.

Parameters:
- NUM_REQ, 3, number of requesters.
- LEN_W, 2, width of per-request burst length field (count-1).
- TIMEOUT, 4096, max cycles in RUN without engine valid before abort.
- WD_W, 13, watchdog counter width (must hold TIMEOUT).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  level request per requester.
- req_len  in  NUM_REQ*LEN_W  per-requester polynomial count minus 1; slice i is [i*LEN_W +: LEN_W].
- grant  out  NUM_REQ  one-hot owner of engine, 0 when idle.
- poly_idx  out  LEN_W  index of polynomial currently in the engine.
- ntt_rst  out  1  active-high synchronous reset to engine.
- ntt_en  out  1  engine enable.
- ntt_valid  in  1  engine result-valid flag.
- poly_done  out  1  1-cycle pulse: current polynomial result valid on engine output.
- req_done  out  NUM_REQ  1-cycle pulse to owner at burst completion.
- err  out  1  1-cycle pulse on watchdog abort.
- busy  out  1  high in every state except IDLE.

Behaviour:
- All outputs are registered, Moore on state.
- Reset (async, reset=0) values: state IDLE; grant 0; poly_idx 0; ntt_rst 1; ntt_en 0; poly_done 0; req_done 0; err 0; busy 0; rr pointer 0; watchdog 0.
- Reset mid-burst aborts immediately with no req_done or err.
- States: IDLE, CLR, RUN, CAPT, FIN, ERR.
- IDLE: ntt_rst=1, ntt_en=0.
  - If any req bit is set, select the first set bit searching from rr pointer upward with wrap (pointer 0 → req0 has top priority after reset).
  - Latch grant one-hot and that requester's req_len into len_q; poly_idx=0; go to CLR.
- CLR (exactly 1 cycle): ntt_rst=1, ntt_en=0, watchdog cleared; go to RUN.
- RUN: ntt_rst=0, ntt_en=1, watchdog increments each cycle.
  - ntt_valid is ignored in the first RUN cycle (stale-valid guard) and sampled from the second RUN cycle on.
  - valid=1 → CAPT.
  - Else, watchdog==TIMEOUT-1 → ERR. Valid wins if both occur in the same cycle.
- CAPT (1 cycle): ntt_en=0, poly_done=1.
  - If poly_idx==len_q → FIN.
  - Else poly_idx+1 → CLR.
- FIN (1 cycle): req_done[owner]=1, grant still held this cycle. Next cycle: grant=0, poly_idx=0, rr pointer = owner+1 mod NUM_REQ, → IDLE.
- ERR (1 cycle): err=1, grant held, no req_done. Then identical release and pointer update as FIN → IDLE.
- Grant and poly_idx are stable from CLR through FIN/ERR inclusive.
- req and req_len are sampled only in IDLE. Deasserting req mid-burst does not shorten the burst.
- Changes to req_len mid-burst are ignored.
- A requester still asserting req after req_done competes again. Rotation guarantees other pending requesters are served first.
- At least one IDLE cycle separates consecutive bursts (ntt_rst stays high).
- Timing, req seen in IDLE at cycle t:
  - grant and CLR at t+1; RUN (ntt_en=1) at t+2.
  - ntt_valid first sampled at t+3.
  - Valid at cycle v → poly_done at v+1.
  - Last poly: req_done at v+2, IDLE at v+3.
- Per extra polynomial: CAPT→CLR→RUN adds 2 cycles of overhead.

Test Plan:
- Single request: req=001, req_len[0]=0, engine model valid 10 cycles after ntt_en rises → grant=001 at t+1; one poly_done at v+1; req_done=001 at v+2; busy low at v+3; err never set.
- Burst: req=010, req_len[1]=2 → three poly_done pulses with poly_idx 0,1,2; ntt_rst high exactly one cycle before each RUN; one req_done=010 after the third.
- Round-robin: req=111 held, all lengths 0 → grant order 001,010,100,001; each grant followed by matching req_done.
- Stale valid: ntt_valid tied high → poly_done two cycles after RUN entry (first RUN cycle ignored), not earlier.
- Timeout: TIMEOUT=16, ntt_valid never asserted → err pulse after 16 RUN cycles; no req_done; grant released; next requester served.
- Async reset: assert reset=0 mid-RUN of a 4-poly burst → all outputs take reset values without waiting for clk; after release, req0 wins if multiple requests are pending.
